fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the core. Walks the PC, issues req/ack reads to
//  instruction memory and presents each instruction to decode over a valid/ready
//  handshake. Takes branch/jump redirects and raises fetch_complete when the program ends.
//  Sits between the instruction memory and decode in TopLevel. fetch_complete is the
//  run-end flag the top-level bench waits on.
// PARAMETERS
//  ADDR_W     32     PC / memory address width
//  INSTR_W    32     instruction width
//  RESET_PC   0      PC loaded on reset
//  PROG_BYTES 1024   program size in bytes; fetch ends when PC >= PROG_BYTES
// PORTS
//  clk            in   1        clock, all state updates on rising edge
//  reset          in   1        synchronous, active-low reset (0 = reset)
//  imem_req       out  1        read request, held until imem_ack
//  imem_addr      out  ADDR_W   read address, stable while imem_req=1
//  imem_ack       in   1        read data valid this cycle
//  imem_rdata     in   INSTR_W  read data
//  redirect_valid in   1        branch/jump redirect strobe
//  redirect_pc    in   ADDR_W   redirect target
//  out_valid      out  1        instruction available to decode
//  out_ready      in   1        decode accepts instruction
//  out_instr      out  INSTR_W  fetched instruction
//  out_pc         out  ADDR_W   address of out_instr
//  pc             out  ADDR_W   next address to fetch
//  fetch_complete out  1        program finished (sticky)
// BEHAVIOUR
//  - All outputs are registered or decoded from the state register. No comb path from inputs.
//  - Reset (reset=0 at edge): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0,
//    fetch_complete=0, imem_req=0, imem_addr=0. Applies from any state, including with a
//    request outstanding; a late ack after reset is ignored.
//  - States: IDLE, REQ, DRAIN, HOLD, DONE.
//    imem_req=1 only in REQ and DRAIN; imem_addr is the latched address.
//  - IDLE: next edge goes to REQ if pc < PROG_BYTES, else to DONE.
//  - REQ: imem_addr=pc. On ack:
//    - imem_rdata==0 (terminator) -> DONE.
//    - otherwise capture out_instr=rdata, out_pc=pc, out_valid=1, pc=pc+4 -> HOLD.
//    Minimum latency: req in cycle N with ack in cycle N -> out_valid in cycle N+1.
//  - HOLD: out_instr/out_pc are stable while out_valid=1 and out_ready=0. No new request
//    is issued. On out_valid&&out_ready: out_valid=0, then go to REQ if pc < PROG_BYTES,
//    else to DONE.
//  - DONE: fetch_complete=1, imem_req=0, out_valid=0. Stays sticky until reset.
//    Redirects are ignored here.
//  - Redirect (any state except DONE/IDLE). redirect_pc[1:0] is forced to 0.
//    - HOLD: pc=redirect_pc, out_valid=0 -> REQ (or DONE if out of range). If
//      out_ready=1 in the same cycle, the handshake counts as accepted.
//    - REQ with ack same cycle: rdata is discarded, pc=redirect_pc -> REQ (new address
//      appears next cycle).
//    - REQ without ack: pc=redirect_pc -> DRAIN.
//    - DRAIN: keep imem_req=1 with the old address; on ack, discard data -> REQ.
//      A further redirect in DRAIN overwrites pc and stays in DRAIN.
//  - pc+4 wraps modulo 2^ADDR_W. The range check (pc >= PROG_BYTES) is unsigned.
// TESTING
//  1. reset=0 for 3 cycles, then release; mem acks with 0 wait, rdata=0x00500093 at 0x0
//     -> imem_req high 1 cycle after release, out_valid next cycle, out_pc=0, pc=4.
//  2. out_ready=0 for 5 cycles with out_valid=1 -> out_instr/out_pc stable, imem_req=0,
//     pc unchanged; out_ready=1 -> next imem_addr=pc.
//  3. rdata=0x00000000 at 0x8 -> fetch_complete=1 next cycle, out_valid stays 0, sticky
//     for 10 more cycles despite redirect_valid pulses.
//  4. ack delayed 3 cycles at 0x4, redirect_pc=0x42 in first waiting cycle
//     -> old data discarded, next imem_addr=0x40, then out_pc=0x40.
//  5. PROG_BYTES=16, 4 nonzero instructions -> 4 handshakes at out_pc 0x0..0xC, then
//     fetch_complete=1 and imem_req=0.
//  6. reset=0 during HOLD with out_valid=1 -> all outputs reset values next edge; after
//     release, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC, reads instruction memory over req/ack
// and hands each instruction to decode over valid/ready, honouring redirects.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       INSTR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [ADDR_W-1:0] PROG_BYTES = ADDR_W'(1024)
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  pc,
   output logic               fetch_complete
);

   typedef enum logic [2:0] {IDLE, REQ, DRAIN, HOLD, DONE} state_t;

   state_t             state, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  opc_q, opc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  redir_pc;
   logic [ADDR_W-1:0]  pc_inc;

   assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign pc_inc   = pc_q + ADDR_W'(4);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= '0;
         opc_q   <= '0;
         instr_q <= '0;
      end else begin
         state   <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         opc_q   <= opc_d;
         instr_q <= instr_d;
      end
   end

   // addr_q is only reloaded on entry to REQ, so DRAIN keeps presenting the
   // address of the outstanding read even after pc has been redirected.
   always_comb begin
      state_d = state;
      pc_d    = pc_q;
      addr_d  = addr_q;
      opc_d   = opc_q;
      instr_d = instr_q;
      case (state)
         IDLE: begin
            addr_d  = pc_q;
            state_d = (pc_q < PROG_BYTES) ? REQ : DONE;
         end
         REQ: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (imem_ack) begin
                  addr_d  = redir_pc;
                  state_d = REQ;
               end else begin
                  state_d = DRAIN;
               end
            end else if (imem_ack) begin
               if (imem_rdata == '0) begin
                  state_d = DONE;
               end else begin
                  instr_d = imem_rdata;
                  opc_d   = pc_q;
                  pc_d    = pc_inc;
                  state_d = HOLD;
               end
            end
         end
         DRAIN: begin
            if (redirect_valid) pc_d = redir_pc;
            if (imem_ack) begin
               addr_d  = redirect_valid ? redir_pc : pc_q;
               state_d = REQ;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               addr_d  = redir_pc;
               state_d = (redir_pc < PROG_BYTES) ? REQ : DONE;
            end else if (out_ready) begin
               addr_d  = pc_q;
               state_d = (pc_q < PROG_BYTES) ? REQ : DONE;
            end
         end
         DONE: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   assign imem_req       = (state == REQ) || (state == DRAIN);
   assign imem_addr      = addr_q;
   assign out_valid      = (state == HOLD);
   assign out_instr      = instr_q;
   assign out_pc         = opc_q;
   assign pc             = pc_q;
   assign fetch_complete = (state == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized runs checked
// against a transaction-level model of the expected instruction stream.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc, pc;
   logic        fetch_complete;

   logic        s_reset;
   logic        s_imem_req, s_imem_ack;
   logic [31:0] s_imem_addr, s_imem_rdata;
   logic        s_redirect_valid;
   logic [31:0] s_redirect_pc;
   logic        s_out_valid, s_out_ready;
   logic [31:0] s_out_instr, s_out_pc, s_pc;
   logic        s_fetch_complete;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned ack_delay = 0;
   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PROG_BYTES(32'd1024)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .pc(pc), .fetch_complete(fetch_complete)
   );

   fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PROG_BYTES(32'd16)) dut_small (
      .clk(clk), .reset(s_reset),
      .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(s_imem_ack), .imem_rdata(s_imem_rdata),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
      .pc(s_pc), .fetch_complete(s_fetch_complete)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a < 32'd1024) return mem[a[9:2]];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] sword(input logic [31:0] a);
      if (a < 32'd16) return 32'h0000_0013 | (((a >> 2) + 32'd1) << 7);
      return 32'h0;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // memory responder: per-request wait of ack_delay cycles, latched when the request starts
   initial begin
      bit          busy;
      int unsigned remain;
      busy = 1'b0; remain = 0;
      imem_ack = 1'b0; imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            if (!busy) begin busy = 1'b1; remain = ack_delay; end
            if (remain == 0) begin
               imem_ack = 1'b1; imem_rdata = memword(imem_addr); busy = 1'b0;
            end else begin
               imem_ack = 1'b0; remain--;
            end
         end else begin
            imem_ack = 1'b0; busy = 1'b0;
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_req"},   32'(imem_req), 32'd0);
      check({tag, "_addr"},  imem_addr, 32'h0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_instr"}, out_instr, 32'h0);
      check({tag, "_opc"},   out_pc, 32'h0);
      check({tag, "_pc"},    pc, 32'h0);
      check({tag, "_done"},  32'(fetch_complete), 32'd0);
   endtask

   initial begin
      logic [31:0] exp_pc, prev_addr, nhs;
      bit          found, done, prev_req, prev_ack;

      reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      s_reset = 1'b0; s_out_ready = 1'b1; s_imem_ack = 1'b0; s_imem_rdata = '0;
      s_redirect_valid = 1'b0; s_redirect_pc = '0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
      mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113; mem[2] = 32'h0; mem[16] = 32'h00a0_0193;

      // reset state, then first fetch with zero-wait memory
      repeat (3) step();
      check_reset_vals("rst");
      reset = 1'b1;
      step();
      check("t1_req", 32'(imem_req), 32'd1);
      check("t1_addr", imem_addr, 32'h0);
      step();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_opc", out_pc, 32'h0);
      check("t1_instr", out_instr, 32'h0050_0093);
      check("t1_pc", pc, 32'h4);

      // decode stalls: output held, no new request
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_valid", 32'(out_valid), 32'd1);
         check("t2_instr", out_instr, 32'h0050_0093);
         check("t2_opc", out_pc, 32'h0);
         check("t2_req", 32'(imem_req), 32'd0);
         check("t2_pc", pc, 32'h4);
      end
      ack_delay = 3;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t2_next_valid", 32'(out_valid), 32'd0);
      check("t2_next_req", 32'(imem_req), 32'd1);
      check("t2_next_addr", imem_addr, 32'h4);

      // redirect while the read at 0x4 is still waiting
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      step();
      redirect_valid = 1'b0;
      ack_delay = 0;
      check("t4_drain_req", 32'(imem_req), 32'd1);
      check("t4_drain_addr", imem_addr, 32'h4);
      check("t4_drain_pc", pc, 32'h40);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req && imem_addr == 32'h40) found = 1'b1;
         else begin
            check("t4_discard", 32'(out_valid), 32'd0);
            step();
         end
      end
      check("t4_newaddr", 32'(found), 32'd1);
      step();
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_opc", out_pc, 32'h40);
      check("t4_instr", out_instr, 32'h00a0_0193);

      // redirect from HOLD onto the terminator at 0x8, then sticky completion
      redirect_valid = 1'b1; redirect_pc = 32'h0A;
      step();
      redirect_valid = 1'b0;
      check("t3_valid", 32'(out_valid), 32'd0);
      check("t3_addr", imem_addr, 32'h8);
      step();
      check("t3_done", 32'(fetch_complete), 32'd1);
      check("t3_valid2", 32'(out_valid), 32'd0);
      check("t3_req", 32'(imem_req), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         redirect_valid = (i % 2 == 0); redirect_pc = 32'h10;
         step();
         check("t3_sticky", 32'(fetch_complete), 32'd1);
         check("t3_sticky_valid", 32'(out_valid), 32'd0);
         check("t3_sticky_req", 32'(imem_req), 32'd0);
      end
      redirect_valid = 1'b0; out_ready = 1'b0;

      // reset in HOLD, and a late ack after reset
      reset = 1'b0; step(); reset = 1'b1;
      step(); step();
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      reset = 1'b0;
      step();
      check_reset_vals("t6");
      reset = 1'b1;
      step();
      check("t6_req", 32'(imem_req), 32'd1);
      check("t6_addr", imem_addr, 32'h0);
      reset = 1'b0;
      step();
      check("t6_lateack_valid", 32'(out_valid), 32'd0);
      check("t6_lateack_pc", pc, 32'h0);
      reset = 1'b1;
      step(); step();
      check("t6_refetch_opc", out_pc, 32'h0);
      check("t6_refetch_instr", out_instr, 32'h0050_0093);

      // 16-byte program: four handshakes then completion
      step(); step();
      s_reset = 1'b1;
      nhs = '0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         step();
         if (s_fetch_complete) done = 1'b1;
         else begin
            if (s_out_valid) begin
               check("t5_opc", s_out_pc, nhs << 2);
               check("t5_instr", s_out_instr, sword(nhs << 2));
               nhs++;
            end
            s_imem_ack   = s_imem_req;
            s_imem_rdata = s_imem_req ? sword(s_imem_addr) : 32'h0;
         end
      end
      s_imem_ack = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_count", nhs, 32'd4);
      check("t5_req", 32'(s_imem_req), 32'd0);

      // randomized runs: each accepted instruction must be the next one of the
      // expected stream; redirects restart the stream at the target
      for (int ep = 0; ep < 4; ep++) begin
         for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 31) == 0) ? 32'h0 : ($urandom | 32'h1);
         reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
         step(); step();
         reset = 1'b1;
         exp_pc = 32'h0; done = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
         for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            step();
            if (fetch_complete) begin
               check("rnd_end_cond", 32'(exp_pc >= 32'd1024 || memword(exp_pc) == 32'h0), 32'd1);
               check("rnd_end_req", 32'(imem_req), 32'd0);
               done = 1'b1;
            end else begin
               if (out_valid) check("rnd_hold_noreq", 32'(imem_req), 32'd0);
               if (imem_req && prev_req && !prev_ack) check("rnd_addr_stable", imem_addr, prev_addr);
               ack_delay      = $urandom_range(0, 3);
               out_ready      = ($urandom_range(0, 3) != 0);
               redirect_valid = (cyc > 2) && ($urandom_range(0, 7) == 0);
               redirect_pc    = $urandom_range(0, 1023);
               if (out_valid && out_ready) begin
                  check("rnd_opc", out_pc, exp_pc);
                  check("rnd_instr", out_instr, memword(exp_pc));
                  exp_pc = exp_pc + 32'd4;
               end
               if (redirect_valid && (imem_req || out_valid)) exp_pc = redirect_pc & 32'hFFFF_FFFC;
               prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
            end
         end
         redirect_valid = 1'b0;
         check("rnd_finished", 32'(done), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
